// File: rtl/pattern_seq_pkg.sv
// Shared definitions for the pattern_seq sequencer: opcodes, instruction field
// positions and the sequencer state encoding.
package pattern_seq_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_SLEEP  = 4'h1;
  localparam logic [3:0] OP_SET    = 4'h2;
  localparam logic [3:0] OP_CLR    = 4'h3;
  localparam logic [3:0] OP_TGL    = 4'h4;
  localparam logic [3:0] OP_JMP    = 4'h5;
  localparam logic [3:0] OP_LDC    = 4'h6;
  localparam logic [3:0] OP_DJNZ   = 4'h7;
  localparam logic [3:0] OP_WAITIN = 4'h8;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam int OPC_HI       = 31;
  localparam int OPC_LO       = 28;
  localparam int WAIT_POL_BIT = 27;
  localparam int IMM_W        = OPC_LO;
  localparam int SEL_W        = 4;

  typedef enum logic [2:0] {
    BOOT,
    FETCH,
    EXEC,
    SLEEP,
    WAIT,
    HALT
  } state_t;

endpackage

// File: rtl/pattern_seq_ram.sv
// Single-clock program RAM, one write port and one read port, read-first on an
// address collision so it maps onto iCE40 block RAM.
module pattern_seq_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/pattern_seq.sv
// Programmable output-pattern sequencer: BOOT delay, then FETCH/EXEC over program RAM.
// Optional PATTERN_SEQ_INPUT_SYNC_EN adds a 2-flop synchroniser on in_pins.
module pattern_seq
  import pattern_seq_pkg::*;
#(
  parameter int              ADDR_W      = 11,
  parameter int              OUT_W       = 8,
  parameter int              IN_W        = 4,
  parameter int              LOOP_W      = 16,
  parameter int              BOOT_CYCLES = 16000,
  parameter logic [OUT_W-1:0] OUT_RESET  = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              pwr_en,
  input  logic [ADDR_W-1:0] pwr_addr,
  input  logic [31:0]       pwr_data,
  input  logic [IN_W-1:0]   in_pins,
  output logic [OUT_W-1:0]  out_q,
  output logic              running,
  output logic              halted,
  output logic              err
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES + 1) : 1;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
  logic [BOOT_W-1:0]  r_boot_cnt, w_boot_nxt;
  logic [IMM_W-1:0]   r_sleep_cnt, w_sleep_nxt;
  logic [LOOP_W-1:0]  r_loop_cnt, w_loop_nxt;
  logic [SEL_W-1:0]   r_wsel, w_wsel_nxt;
  logic               r_wpol, w_wpol_nxt;
  logic [OUT_W-1:0]   w_out_nxt;
  logic               w_err_nxt;

  logic [31:0]        w_instr;
  logic [3:0]         w_opc;
  logic [IMM_W-1:0]   w_imm;
  logic [SEL_W-1:0]   w_sel;
  logic               w_sel_ok;
  logic [IN_W-1:0]    w_in;
  logic [15:0]        w_in_ext;

  pattern_seq_ram #(.ADDR_W(ADDR_W), .DATA_W(32)) u_ram (
    .clk     (CLK),
    .i_we    (pwr_en),
    .i_waddr (pwr_addr),
    .i_wdata (pwr_data),
    .i_re    (r_state == FETCH),
    .i_raddr (r_pc),
    .o_rdata (w_instr)
  );

`ifdef PATTERN_SEQ_INPUT_SYNC_EN
  logic [IN_W-1:0] r_sync1, r_sync2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_pins;
      r_sync2 <= r_sync1;
    end
  end

  assign w_in = r_sync2;
`else
  assign w_in = in_pins;
`endif

  assign w_opc    = w_instr[OPC_HI:OPC_LO];
  assign w_imm    = w_instr[OPC_LO-1:0];
  assign w_sel    = w_imm[SEL_W-1:0];
  assign w_sel_ok = (32'(w_sel) < IN_W);
  assign w_in_ext = 16'(w_in);

  assign running  = (r_state == FETCH) || (r_state == EXEC) ||
                    (r_state == SLEEP) || (r_state == WAIT);
  assign halted   = (r_state == HALT);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_boot_nxt  = r_boot_cnt;
    w_sleep_nxt = r_sleep_cnt;
    w_loop_nxt  = r_loop_cnt;
    w_wsel_nxt  = r_wsel;
    w_wpol_nxt  = r_wpol;
    w_out_nxt   = out_q;
    w_err_nxt   = err;
    case (r_state)
      // Leaves after exactly BOOT_CYCLES cycles so RAM loading can finish first.
      BOOT: begin
        if (r_boot_cnt <= BOOT_W'(1)) begin
          w_boot_nxt  = '0;
          w_state_nxt = FETCH;
        end else begin
          w_boot_nxt = r_boot_cnt - BOOT_W'(1);
        end
      end
      FETCH: w_state_nxt = EXEC;
      EXEC: begin
        w_state_nxt = FETCH;
        w_pc_nxt    = r_pc + ADDR_W'(1);
        case (w_opc)
          OP_NOP: ;
          OP_SLEEP: begin
            w_sleep_nxt = w_imm;
            w_state_nxt = SLEEP;
          end
          OP_SET:  w_out_nxt = out_q | w_imm[OUT_W-1:0];
          OP_CLR:  w_out_nxt = out_q & ~w_imm[OUT_W-1:0];
          OP_TGL:  w_out_nxt = out_q ^ w_imm[OUT_W-1:0];
          OP_JMP:  w_pc_nxt  = w_imm[ADDR_W-1:0];
          OP_LDC:  w_loop_nxt = w_imm[LOOP_W-1:0];
          OP_DJNZ: begin
            // A zero count falls through without wrapping to all-ones.
            if (r_loop_cnt > LOOP_W'(1)) begin
              w_loop_nxt = r_loop_cnt - LOOP_W'(1);
              w_pc_nxt   = w_imm[ADDR_W-1:0];
            end else begin
              w_loop_nxt = '0;
            end
          end
          OP_WAITIN: begin
            if (w_sel_ok) begin
              w_wsel_nxt  = w_sel;
              w_wpol_nxt  = w_imm[WAIT_POL_BIT];
              w_state_nxt = WAIT;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
          OP_HALT: begin
            w_pc_nxt    = r_pc;
            w_state_nxt = HALT;
          end
          default: w_err_nxt = 1'b1;
        endcase
      end
      SLEEP: begin
        if (r_sleep_cnt == '0) w_state_nxt = FETCH;
        else                   w_sleep_nxt = r_sleep_cnt - IMM_W'(1);
      end
      WAIT: begin
        if (w_in_ext[r_wsel] == r_wpol) w_state_nxt = FETCH;
      end
      HALT: ;
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= BOOT;
      r_pc        <= '0;
      r_boot_cnt  <= BOOT_W'(BOOT_CYCLES);
      r_sleep_cnt <= '0;
      r_loop_cnt  <= '0;
      r_wsel      <= '0;
      r_wpol      <= 1'b0;
      out_q       <= OUT_RESET;
      err         <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_boot_cnt  <= w_boot_nxt;
      r_sleep_cnt <= w_sleep_nxt;
      r_loop_cnt  <= w_loop_nxt;
      r_wsel      <= w_wsel_nxt;
      r_wpol      <= w_wpol_nxt;
      out_q       <= w_out_nxt;
      err         <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_pattern_seq.sv
// Bench for pattern_seq: instruction-level reference model producing a per-cycle
// expectation list, plus directed waits, reset abort and read-first collision.
module tb_pattern_seq;

  localparam int         ADDR_W    = 4;
  localparam int         DEPTH     = 2**ADDR_W;
  localparam int         OUT_W     = 8;
  localparam int         IN_W      = 4;
  localparam int         LOOP_W    = 16;
  localparam int         BOOT      = 10;
  localparam logic [7:0] OUT_RST   = 8'h5A;
`ifdef PATTERN_SEQ_INPUT_SYNC_EN
  localparam int         SYNC_LAT  = 2;
`else
  localparam int         SYNC_LAT  = 0;
`endif

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              pwr_en = 1'b0;
  logic [ADDR_W-1:0] pwr_addr = '0;
  logic [31:0]       pwr_data = '0;
  logic [IN_W-1:0]   in_pins = '0;
  logic [OUT_W-1:0]  out_q;
  logic              running, halted, err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [31:0] prog [DEPTH];
  logic [31:0] expq [$];

  pattern_seq #(
    .ADDR_W(ADDR_W), .OUT_W(OUT_W), .IN_W(IN_W), .LOOP_W(LOOP_W),
    .BOOT_CYCLES(BOOT), .OUT_RESET(OUT_RST)
  ) dut (
    .CLK(CLK), .RST(RST), .pwr_en(pwr_en), .pwr_addr(pwr_addr), .pwr_data(pwr_data),
    .in_pins(in_pins), .out_q(out_q), .running(running), .halted(halted), .err(err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] pack(logic [7:0] o, logic r, logic h, logic e);
    return {21'd0, o, r, h, e};
  endfunction

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc %0d: observed %h expected %h", tag, c, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick();
  endtask

  // Loads the whole program while reset is held; returns in cycle 0 of BOOT.
  task automatic load_and_reset();
    RST = 1'b1;
    pwr_en = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      pwr_addr = ADDR_W'(a);
      pwr_data = prog[a];
      tick();
    end
    pwr_en = 1'b0;
    RST = 1'b0;
    cyc = 0;
  endtask

  task automatic clear_prog();
    for (int a = 0; a < DEPTH; a++) prog[a] = 32'h0000_0000;
  endtask

  // Instruction-level model: each instruction costs FETCH+EXEC showing the old
  // state, then any SLEEP/WAIT cycles showing the new state.
  task automatic build_model(input int ncyc);
    logic [7:0]  o;
    logic [31:0] ins;
    logic [27:0] imm;
    logic [3:0]  opc;
    int pc, npc, lc, extra, sel;
    bit e, stuck, hlt;
    expq.delete();
    for (int i = 0; i < BOOT; i++) expq.push_back(pack(OUT_RST, 0, 0, 0));
    o = OUT_RST; pc = 0; lc = 0; e = 0; hlt = 0;
    while (expq.size() < ncyc && !hlt) begin
      ins = prog[pc];
      opc = ins[31:28];
      imm = ins[27:0];
      expq.push_back(pack(o, 1, 0, e));
      expq.push_back(pack(o, 1, 0, e));
      extra = 0; stuck = 0;
      npc = (pc + 1) % DEPTH;
      case (opc)
        4'h0: ;
        4'h1: extra = int'(imm) + 1;
        4'h2: o = o | imm[7:0];
        4'h3: o = o & ~imm[7:0];
        4'h4: o = o ^ imm[7:0];
        4'h5: npc = int'(imm) % DEPTH;
        4'h6: lc = int'(imm) % (1 << LOOP_W);
        4'h7: begin
          if (lc > 1) begin lc = lc - 1; npc = int'(imm) % DEPTH; end
          else lc = 0;
        end
        4'h8: begin
          sel = int'(imm[3:0]);
          if (sel >= IN_W) e = 1;
          else if (in_pins[sel] == imm[27]) extra = 1;
          else stuck = 1;
        end
        4'hF: hlt = 1;
        default: e = 1;
      endcase
      if (hlt) while (expq.size() < ncyc) expq.push_back(pack(o, 0, 1, e));
      if (stuck) while (expq.size() < ncyc) expq.push_back(pack(o, 1, 0, e));
      repeat (extra) expq.push_back(pack(o, 1, 0, e));
      pc = npc;
    end
  endtask

  task automatic run_check(input string tag, input int ncyc, input int wr_cyc, input logic [31:0] wr_word);
    for (int c = 0; c < ncyc; c++) begin
      chk(tag, c, pack(out_q, running, halted, err), expq[c]);
      if (c == wr_cyc) begin
        pwr_en = 1'b1; pwr_addr = '0; pwr_data = wr_word;
      end else begin
        pwr_en = 1'b0;
      end
      tick();
    end
    pwr_en = 1'b0;
  endtask

  function automatic logic [31:0] rnd_instr();
    int k;
    logic [27:0] r;
    k = $urandom_range(0, 13);
    r = 28'($urandom);
    case (k)
      0:  return {4'h0, r};
      1:  return {4'h1, 25'd0, 3'($urandom_range(0, 7))};
      2:  return {4'h2, r};
      3:  return {4'h3, r};
      4:  return {4'h4, r};
      5:  return {4'h5, r};
      6:  return {4'h6, r[27:16], 13'd0, 3'($urandom_range(0, 4))};
      7:  return {4'h7, r};
      8:  return {4'h8, r[27:4], 4'($urandom_range(0, 5))};
      9:  return {4'($urandom_range(9, 14)), r};
      10: return {4'hF, r};
      default: return {4'h4, r};
    endcase
  endfunction

  initial begin
    // Write during the BOOT window replaces the word at address 0.
    clear_prog();
    prog[1] = 32'hF000_0000;
    load_and_reset();
    prog[0] = 32'h2000_0001;
    build_model(40);
    run_check("boot_load", 40, 3, 32'h2000_0001);

    // Blink loop: SET 1, SLEEP 5, CLR 1, SLEEP 5, JMP 0.
    clear_prog();
    prog[0] = 32'h2000_0001; prog[1] = 32'h1000_0005; prog[2] = 32'h3000_0001;
    prog[3] = 32'h1000_0005; prog[4] = 32'h5000_0000;
    load_and_reset();
    build_model(120);
    run_check("blink", 120, -1, 32'h0);

    // Counted loop: LDC 3; TGL 4; DJNZ 1; HALT.
    clear_prog();
    prog[0] = 32'h6000_0003; prog[1] = 32'h4000_0004;
    prog[2] = 32'h7000_0001; prog[3] = 32'hF000_0000;
    load_and_reset();
    build_model(60);
    run_check("djnz", 60, -1, 32'h0);

    // Illegal opcode, then illegal WAITIN select, then HALT.
    clear_prog();
    prog[0] = 32'hA000_0000; prog[1] = 32'h2000_0002;
    prog[2] = 32'h8000_0007; prog[3] = 32'hF000_0000;
    load_and_reset();
    build_model(40);
    run_check("illegal", 40, -1, 32'h0);

    // PC wrap: single TGL followed by NOPs around the whole RAM.
    clear_prog();
    prog[0] = 32'h4000_0001;
    load_and_reset();
    build_model(110);
    run_check("pc_wrap", 110, -1, 32'h0);

    // Randomised programs with constant inputs.
    for (int t = 0; t < 6; t++) begin
      for (int a = 0; a < DEPTH; a++) prog[a] = rnd_instr();
      in_pins = 4'($urandom);
      load_and_reset();
      build_model(150);
      run_check("random", 150, -1, 32'h0);
    end

    // WAITIN sel 2 polarity 1; input rises 20 cycles into WAIT.
    clear_prog();
    prog[0] = 32'h8800_0002; prog[1] = 32'h2000_0001; prog[2] = 32'hF000_0000;
    in_pins = '0;
    load_and_reset();
    tick_to(31);
    chk("wait_hold_run", cyc, 32'(running), 32'd1);
    chk("wait_hold_out", cyc, 32'(out_q), 32'h5A);
    tick_to(32);
    in_pins = 4'b0100;
    tick_to(33 + SYNC_LAT);
    chk("wait_resume_run", cyc, 32'(running), 32'd1);
    tick_to(34 + SYNC_LAT);
    chk("wait_before_set", cyc, 32'(out_q), 32'h5A);
    tick_to(35 + SYNC_LAT);
    chk("wait_after_set", cyc, 32'(out_q), 32'h5B);
    tick_to(37 + SYNC_LAT);
    chk("wait_halted", cyc, 32'(halted), 32'd1);
    in_pins = '0;

    // Reset while SLEEP 1000 has counted down to 500.
    clear_prog();
    prog[0] = 32'h2000_0003; prog[1] = 32'h1000_03E8; prog[2] = 32'hF000_0000;
    load_and_reset();
    tick_to(514);
    chk("sleep_out", cyc, 32'(out_q), 32'h5B);
    chk("sleep_run", cyc, 32'(running), 32'd1);
    RST = 1'b1;
    tick();
    chk("abort_out", cyc, 32'(out_q), 32'h5A);
    chk("abort_flags", cyc, {29'd0, running, halted, err}, 32'd0);
    RST = 1'b0;
    cyc = 0;
    tick_to(9);
    chk("reboot_idle", cyc, 32'(running), 32'd0);
    tick_to(10);
    chk("reboot_run", cyc, 32'(running), 32'd1);
    tick_to(12);
    chk("reboot_pc0", cyc, 32'(out_q), 32'h5B);

    // Read-first: overwrite address 0 in the very cycle it is fetched.
    clear_prog();
    prog[0] = 32'h4000_0001; prog[1] = 32'h5000_0000;
    load_and_reset();
    tick_to(13);
    chk("rf_first", cyc, 32'(out_q), 32'h5B);
    tick_to(14);
    pwr_en = 1'b1; pwr_addr = '0; pwr_data = 32'h4000_0002;
    tick();
    pwr_en = 1'b0;
    tick_to(17);
    chk("rf_old_word", cyc, 32'(out_q), 32'h5A);
    tick_to(21);
    chk("rf_new_word", cyc, 32'(out_q), 32'h58);
    tick_to(25);
    chk("rf_new_again", cyc, 32'(out_q), 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
